// File: rtl/peak_pkg.sv
// Shared types and helpers for the multi-channel correlation peak finder.
package peak_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All-ones pattern of the given lag width (callers cast down to their width).
  // 2*MAX_LAGS+1 is odd, so this value can never be a legal lag index.
  function automatic logic [31:0] lag_sentinel(input int unsigned width);
    if (width >= 32) begin
      lag_sentinel = '1;
    end else begin
      lag_sentinel = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/peak_tracker.sv
// Running maximum tracker for one correlation channel.
// The first enabled sample after a clear always loads; later samples replace
// the max only when strictly greater (signed), so ties keep the lowest lag.
// best_max_o/best_lag_o expose the value the tracker will hold after this
// edge, letting the parent capture the final result on the last lag's edge.
module peak_tracker #(
  parameter int W     = 34,
  parameter int LAG_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic signed [W-1:0] sample_i,
  input  logic [LAG_W-1:0]    lag_i,
  output logic signed [W-1:0] best_max_o,
  output logic [LAG_W-1:0]    best_lag_o
);

  logic signed [W-1:0] max_q, max_d;
  logic [LAG_W-1:0]    lag_q, lag_d;
  logic                loaded_q, loaded_d;

  // Next-state: clear, first load, or strict signed improvement.
  always_comb begin
    max_d    = max_q;
    lag_d    = lag_q;
    loaded_d = loaded_q;
    if (clear_i) begin
      max_d    = '0;
      lag_d    = '0;
      loaded_d = 1'b0;
    end else if (enable_i && (!loaded_q || (sample_i > max_q))) begin
      max_d    = sample_i;
      lag_d    = lag_i;
      loaded_d = 1'b1;
    end
  end

  // Running max registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q    <= '0;
      lag_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      max_q    <= max_d;
      lag_q    <= lag_d;
      loaded_q <= loaded_d;
    end
  end

  assign best_max_o = max_d;
  assign best_lag_o = lag_d;

endmodule

// File: rtl/multi_peak_finder.sv
// Handshaked multi-channel cross-correlation peak finder.
//
// state   | meaning
// IDLE    | waiting for start; latches threshold and clears trackers on start
// SCAN    | one lag per cycle, lag counter 0 .. 2*MAX_LAGS
// DONE    | results registered, done pulse high, returns to IDLE
module multi_peak_finder
  import peak_pkg::*;
#(
  parameter int   NUM_BITS_XCORRS = 34,
  parameter int   MAX_LAGS        = 17,
  parameter int   NUM_CHANNELS    = 3,
  localparam int  LAG_W           = $clog2(2*MAX_LAGS+1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic signed [NUM_BITS_XCORRS-1:0] dataIn [NUM_CHANNELS][2*MAX_LAGS+1],
  input  logic signed [NUM_BITS_XCORRS-1:0] minXcorr,
  output logic                              busy,
  output logic                              done,
  output logic [LAG_W-1:0]                  lagOut [NUM_CHANNELS],
  output logic signed [NUM_BITS_XCORRS-1:0] peakOut [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]           peakValid
);

  localparam logic [LAG_W-1:0] LAG_SENTINEL = LAG_W'(lag_sentinel(LAG_W));
  localparam logic [LAG_W-1:0] LAG_LAST     = LAG_W'(2*MAX_LAGS);

  state_e                              state_q;
  logic [LAG_W-1:0]                    lag_cnt_q;
  logic signed [NUM_BITS_XCORRS-1:0]   thr_q;
  logic                                busy_q;
  logic                                done_q;
  logic [LAG_W-1:0]                    lag_out_q  [NUM_CHANNELS];
  logic signed [NUM_BITS_XCORRS-1:0]   peak_out_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]             valid_q;

  logic                                trk_clear;
  logic                                trk_enable;
  logic signed [NUM_BITS_XCORRS-1:0]   best_max [NUM_CHANNELS];
  logic [LAG_W-1:0]                    best_lag [NUM_CHANNELS];

  assign trk_clear  = (state_q == ST_IDLE) && start;
  assign trk_enable = (state_q == ST_SCAN);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_trk
    peak_tracker #(
      .W     (NUM_BITS_XCORRS),
      .LAG_W (LAG_W)
    ) u_trk (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (trk_clear),
      .enable_i   (trk_enable),
      .sample_i   (dataIn[c][lag_cnt_q]),
      .lag_i      (lag_cnt_q),
      .best_max_o (best_max[c]),
      .best_lag_o (best_lag[c])
    );
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lag_cnt_q <= '0;
      thr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        lag_out_q[c]  <= LAG_SENTINEL;
        peak_out_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            thr_q     <= minXcorr;
            lag_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (lag_cnt_q == LAG_LAST) begin
            // Capture the trackers' post-last-lag values on this same edge.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              peak_out_q[c] <= best_max[c];
              valid_q[c]    <= (best_max[c] > thr_q);
              lag_out_q[c]  <= (best_max[c] > thr_q) ? best_lag[c] : LAG_SENTINEL;
            end
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            lag_cnt_q <= lag_cnt_q + LAG_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign lagOut    = lag_out_q;
  assign peakOut   = peak_out_q;
  assign peakValid = valid_q;

endmodule

// File: doc/multi_peak_finder.md
# multi_peak_finder

Multi-channel, handshaked cross-correlation peak finder. Given one correlation vector per microphone pair, it scans all 2*MAX_LAGS+1 lags sequentially after a start pulse. It returns, per channel, the lag index and value of the largest correlation, plus a validity flag against a run-time threshold. It sits between the cross-correlator array and the direction-of-arrival stage, replacing the single-channel free-running peak tracker.

## Interface
- NUM_BITS_XCORRS, 34, width of one signed correlation value
- MAX_LAGS, 17, lags span -MAX_LAGS..+MAX_LAGS; must be >= 1
- NUM_CHANNELS, 3, number of independent correlation vectors
- LAG_W, $clog2(2*MAX_LAGS+1), localparam, lag index width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request a scan; honoured only in IDLE
- dataIn  in  [NUM_CHANNELS][2*MAX_LAGS+1][NUM_BITS_XCORRS] signed  correlation vectors; must be held stable while busy
- minXcorr  in  NUM_BITS_XCORRS signed  validity threshold; sampled when start is accepted
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse when results update
- lagOut  out  [NUM_CHANNELS][LAG_W]  peak lag index 0..2*MAX_LAGS (index MAX_LAGS = zero lag); all-ones when invalid
- peakOut  out  [NUM_CHANNELS][NUM_BITS_XCORRS] signed  peak value
- peakValid  out  [NUM_CHANNELS]  peak strictly greater than threshold

## Operation
- FSM states:
  - IDLE: on start, clear trackers, latch minXcorr, lagCnt<=0, go to SCAN.
  - SCAN: each cycle every channel compares dataIn[c][lagCnt] against its running max.
    - Lag 0 always loads.
    - Later lags update only on strict signed greater-than, so on ties the lowest lag wins.
    - After lagCnt = 2*MAX_LAGS, go to DONE; otherwise lagCnt+1.
  - DONE: register results to outputs, assert done, go to IDLE.
- Comparison and threshold are fully signed. All-negative vectors yield the least-negative lag.
- peakValid[c] = (max[c] > latched minXcorr); equality is invalid.
- Invalid channel: lagOut[c] = all-ones. This value is never a legal lag, since 2*MAX_LAGS+1 is odd and never a power of two. peakOut[c] still carries the max.
- Outputs hold their last result until the next done. The interior running max is not visible.
- start in SCAN/DONE is ignored, not queued.
- No arithmetic widening; values pass through unchanged.

## Timing
- start sampled at edge T means:
  - SCAN occupies cycles T+1 .. T+2*MAX_LAGS+1.
  - done is high in cycle T+2*MAX_LAGS+2 (36 cycles for default), with outputs valid that same cycle.
- busy rises the cycle after start is accepted and falls with DONE->IDLE. A new start is accepted in the first IDLE cycle after done.
- Reset values: busy=0, done=0, lagOut=all-ones, peakOut=0, peakValid=0, state=IDLE, lagCnt=0.
- rst_n low mid-scan: next edge forces reset values. No done is produced and the partial scan is discarded.
- rst_n and start together: reset wins.

## Structure
- Shared package peak_pkg:
  - state enum (IDLE, SCAN, DONE)
  - lag-sentinel function returning all-ones of LAG_W
- Sub-module peak_tracker, one per channel via generate:
  - holds running max and its index
  - inputs: clear, enable, sample, lag

## Test plan
- Defaults. ch0 value 5000 at lag 20, all else 0, minXcorr=1000 -> done 36 cycles after start; lagOut[0]=20, peakOut[0]=5000, peakValid[0]=1; ch1/ch2 lagOut=63, peakValid=0, peakOut=0.
- ch1 value 3000 at lags 4 and 30 -> lagOut[1]=4. Peak of exactly 1000 with minXcorr=1000 -> peakValid=0, lagOut=63.
- ch2 all negative, max -10 at lag 7, minXcorr=-100 -> lagOut[2]=7, peakValid[2]=1.
- Peak at lag 34 (last) and lag 32 -> reported as 34 and 32, distinct from sentinel 63.
- start re-pulsed at scan cycle 5 -> single done at cycle 36. Then rst_n low at scan cycle 10 of a second run -> busy=0 next cycle, no done, outputs at reset values; a following start completes normally.
